// File: rtl/snn_input_loader.sv
// rtl/snn_input_loader.sv - byte-serial image loader and pixel server for the SNN core
// Buffers one binary image, starts the core, serves its pixel reads and returns its digit.
module snn_input_loader #(
  parameter int NUM_BYTES = 98,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  input  logic              flush,
  output logic              start,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              q_input,
  input  logic              done,
  input  logic [3:0]        digit,
  output logic [3:0]        result,
  output logic              result_vld,
  output logic              busy,
  output logic              overrun,
  output logic [6:0]        byte_cnt
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  localparam logic [6:0]        LAST_BYTE = 7'(NUM_BYTES - 1);
  localparam logic [ADDR_W:0]   NUM_PIX   = (ADDR_W + 1)'(NUM_BYTES * 8);

  logic [1:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       overrun_q, overrun_d;
  logic [3:0] result_q, result_d;
  logic       vld_q, vld_d;
  logic       q_input_q, q_input_d;
  logic       wr_en;

  logic [7:0] mem_q [NUM_BYTES];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    result_d  = result_q;
    vld_d     = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        // flush beats a same-cycle byte: nothing is written
        if (flush) begin
          cnt_d = '0;
        end else if (rx_rdy) begin
          wr_en = 1'b1;
          if (cnt_q == '0) overrun_d = 1'b0;
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_START: begin
        if (rx_rdy) overrun_d = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (rx_rdy) overrun_d = 1'b1;
        if (done) begin
          result_d = digit;
          vld_d    = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  logic [ADDR_W-4:0] rd_idx;
  assign rd_idx    = addr_input_unit[ADDR_W-1:3];
  assign q_input_d = ({1'b0, addr_input_unit} < NUM_PIX) ? mem_q[rd_idx][addr_input_unit[2:0]] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      result_q  <= '0;
      vld_q     <= 1'b0;
      q_input_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      result_q  <= result_d;
      vld_q     <= vld_d;
      q_input_q <= q_input_d;
    end
  end

  // Image storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q] <= rx_data;
  end

  assign start      = (state_q == ST_START);
  assign busy       = (state_q != ST_LOAD);
  assign overrun    = overrun_q;
  assign byte_cnt   = cnt_q;
  assign result     = result_q;
  assign result_vld = vld_q;
  assign q_input    = q_input_q;

endmodule
